user_io_arbiter: RTL
====================

# user_io_arbiter

Shares one group of user-project GPIO pads (`io_out`/`io_oeb`/`io_in` slice of `mprj_io`) between several on-chip requesters inside `user_project_wrapper`. Round-robin grant with bounded hold time and a forced all-input turnaround window between owners, so that no two drivers ever contend on a bidirectional pad. It also provides a synchronised copy of the pad inputs to every requester.

## Interface

Parameters:
- `NREQ`, 3: number of requesters; 2..8.
- `WIDTH`, 8: number of pads in the shared group.
- `TURN`, 2: turnaround cycles with all pads tri-stated between owners; must be ≥ 1.
- `MAX_HOLD`, 256: maximum granted cycles while another requester waits; 0 = unlimited.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  level request; held high for as long as ownership is wanted.
- `out_data`  in  NREQ*WIDTH  per-requester pad output values; requester i uses slice [i*WIDTH +: WIDTH].
- `out_oeb`  in  NREQ*WIDTH  per-requester output enables, active-low.
- `grant`  out  NREQ  one-hot or zero; registered.
- `preempt`  out  1  one-cycle pulse when the owner is removed by hold timeout.
- `busy`  out  1  high whenever the state is not IDLE.
- `io_out`  out  WIDTH  to the pads.
- `io_oeb`  out  WIDTH  to the pads; 1 = input.
- `io_in`  in  WIDTH  from the pads; asynchronous.
- `in_sync`  out  WIDTH  `io_in` after two flops.

## Operation

- Reset values: `grant`=0, `preempt`=0, `busy`=0, `io_out`=0, `io_oeb`=all 1, `in_sync`=0, state IDLE, round-robin pointer=0, hold counter=0.
- States: IDLE, TURN, OWN.
- IDLE:
  - All pads are inputs.
  - When any `req` is high, select the first requester at or after the pointer (wrapping) and latch it as the candidate.
  - Move to TURN with the turn counter at 0.
- TURN:
  - All pads remain inputs and `grant`=0.
  - The counter increments every cycle; after `TURN` cycles, move to OWN and assert `grant[cand]`.
  - If `req[cand]` drops during TURN, return to IDLE with no grant issued; the pointer is unchanged.
- OWN:
  - `io_out`/`io_oeb` are registered copies of the owner's slices.
  - The hold counter increments each cycle and saturates at `MAX_HOLD`.
- OWN exit:
  - (a) `req[owner]` low → release.
  - (b) `MAX_HOLD`≠0, the counter has reached `MAX_HOLD`, and some other `req` is high → release and pulse `preempt`.
  - Both (a) and (b) in the same cycle → treat as (a); no `preempt`.
- On release:
  - `grant`=0 and `io_oeb`=all 1 at the same edge.
  - Pointer becomes owner+1 (mod NREQ).
  - The hold counter clears.
  - If any other requester is pending, go directly to TURN with a new candidate chosen from the updated pointer; otherwise go to IDLE.
- The owner's own `req` is ignored for re-selection in the release cycle. It is eligible again on the next arbitration.
- `in_sync` is independent of state.
- Reset asserted in any state returns every output to its reset value at the next edge. Pads are tri-stated immediately; no turnaround is applied.

## Timing

- Requests:
  - `req[i]` rises before edge 0 in IDLE → TURN after edge 0.
  - `grant[i]` is high after edge `TURN`, so request-to-grant latency is `TURN`+1 cycles.
- Data path:
  - At the edge where `grant` rises, `io_out`/`io_oeb` load the owner's values sampled at that edge.
  - Afterwards, pad values lag `out_data`/`out_oeb` by exactly one cycle.
- Release: `req[owner]` low before edge k → `grant`=0 and `io_oeb`=all 1 after edge k.
- Owner to owner: minimum gap of `TURN` cycles with all pads tri-stated.
- Preemption: under contention present from grant onward, `grant` stays high for exactly `MAX_HOLD` cycles.
- `in_sync` latency is 2 cycles.

## Structure

- Package `user_io_arbiter_pkg` holds:
  - the state enum (IDLE/TURN/OWN);
  - the function that picks the next requester in round-robin order from a pointer;
  - the all-inputs `io_oeb` constant.
- Sub-module `io_in_sync`: `WIDTH`-bit, 2-flop synchroniser with synchronous reset to 0.
- Everything else lives in `user_io_arbiter`.

## Test plan

All scenarios use NREQ=3, WIDTH=8.

- **Single requester (TURN=2):** `req`=3'b010 at cycle 0 with `out_data[15:8]`=8'h5A and `out_oeb[15:8]`=0 → `grant`=3'b010 from cycle 3, `io_out`=8'h5A, `io_oeb`=8'h00; drop `req` → next cycle `grant`=0, `io_oeb`=8'hFF, `busy`=0.
- **Round robin:** `req`=3'b111 held, each owner drops its `req` after 5 cycles then re-raises it → grant order 0,1,2,0; at least 2 cycles of `io_oeb`=8'hFF between owners.
- **Preempt (MAX_HOLD=4):** requester 0 owns and requester 2 raises `req` → `grant[0]` high exactly 4 cycles, one-cycle `preempt`, `grant`=3'b100 `TURN`+1 cycles later.
- **Abort in TURN:** `req[1]` pulses for 1 cycle → `busy` pulses, `grant` stays 0, `io_oeb` stays 8'hFF.
- **Reset mid-OWN:** `wb_rst_i` high for 1 cycle while requester 2 drives 8'hA5 → next cycle `grant`=0, `io_out`=0, `io_oeb`=8'hFF, `in_sync`=0, pointer=0.
- **Input sync:** `io_in` steps 8'h00→8'h3C → `in_sync`=8'h3C exactly 2 edges later, in every state.

Source files
------------

// File: rtl/user_io_arbiter_pkg.sv
// Shared types and helpers for the user IO pad arbiter.
package user_io_arbiter_pkg;

    // Arbiter states: idle, tri-stated turnaround, and pad ownership.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_e;

    // Widest requester vector the round-robin picker handles.
    localparam int MAX_REQ = 8;

    // All pads configured as inputs; sliced down to the group width by users.
    localparam logic [63:0] OEB_ALL_IN = '1;

    // First set bit of reqv at or after ptr, wrapping modulo nreq.
    // Returns 0 when nothing is requested; callers qualify with |reqv.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] reqv,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (!found && (i < nreq) && reqv[idx[2:0]]) begin
                sel   = idx[2:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_in_sync.sv
// Two-flop synchroniser for the asynchronous pad inputs.
module io_in_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives a clean copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/user_io_arbiter.sv
// Round-robin owner of a shared group of user GPIO pads. A new owner only
// gets the pads after TURN cycles with every pad tri-stated, so two drivers
// never fight on a bidirectional pad. Hold time is bounded by MAX_HOLD when
// someone else is waiting.
module user_io_arbiter
    import user_io_arbiter_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int WIDTH    = 8,
    parameter int TURN     = 2,
    parameter int MAX_HOLD = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   out_data,
    input  logic [NREQ*WIDTH-1:0]   out_oeb,
    output logic [NREQ-1:0]         grant,
    output logic                    preempt,
    output logic                    busy,
    output logic [WIDTH-1:0]        io_out,
    output logic [WIDTH-1:0]        io_oeb,
    input  logic [WIDTH-1:0]        io_in,
    output logic [WIDTH-1:0]        in_sync
);

    // Turn counter runs 0..TURN-1; hold counter runs 0..MAX_HOLD.
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [TW-1:0]    TLAST  = TW'(TURN - 1);
    localparam logic [HW-1:0]    HMAX   = HW'(MAX_HOLD);
    localparam logic [2:0]       LAST   = 3'(NREQ - 1);
    localparam logic [WIDTH-1:0] OEB_IN = OEB_ALL_IN[WIDTH-1:0];

    arb_state_e      state, state_nxt;
    logic [2:0]      ptr, ptr_nxt;
    logic [2:0]      cand, cand_nxt;      // candidate in TURN, owner in OWN
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [HW-1:0]   hold, hold_nxt, hold_inc;
    logic [NREQ-1:0] grant_nxt;
    logic            preempt_nxt;
    logic            timeout;

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] others;           // everyone except the current cand
    logic [2:0]         ptr_after;        // cand + 1, wrapped
    logic [2:0]         pick_idle;
    logic [2:0]         pick_rel;

    logic [MAX_REQ-1:0][WIDTH-1:0] od_arr;
    logic [MAX_REQ-1:0][WIDTH-1:0] oe_arr;

    // Per-requester pad slices, zero-padded up to MAX_REQ so the owner mux
    // can be indexed with the 3-bit owner id without range issues.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_slice
        if (g < NREQ) begin : g_on
            assign od_arr[g] = out_data[g*WIDTH +: WIDTH];
            assign oe_arr[g] = out_oeb[g*WIDTH +: WIDTH];
        end else begin : g_off
            assign od_arr[g] = '0;
            assign oe_arr[g] = OEB_IN;
        end
    end

    assign req_ext   = MAX_REQ'(req);
    assign others    = req_ext & ~(MAX_REQ'(1) << cand);
    assign ptr_after = (cand == LAST) ? 3'd0 : cand + 3'd1;
    assign pick_idle = rr_pick(req_ext, ptr, NREQ);
    // The outgoing owner is masked out so it cannot win straight back.
    assign pick_rel  = rr_pick(others, ptr_after, NREQ);
    assign hold_inc  = (hold == HMAX) ? hold : hold + 1'b1;
    assign busy      = (state != ST_IDLE);

    // Next-state and next-output decode for the arbiter.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cand_nxt    = cand;
        tcnt_nxt    = tcnt;
        hold_nxt    = hold;
        grant_nxt   = grant;
        preempt_nxt = 1'b0;
        timeout     = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                if (|req_ext) begin
                    cand_nxt  = pick_idle;
                    tcnt_nxt  = '0;
                    state_nxt = ST_TURN;
                end
            end
            ST_TURN: begin
                grant_nxt = '0;
                if (!req_ext[cand]) begin
                    // Candidate gave up during turnaround; pointer stays put.
                    state_nxt = ST_IDLE;
                end else if (tcnt == TLAST) begin
                    state_nxt = ST_OWN;
                    grant_nxt = NREQ'(1) << cand;
                    hold_nxt  = '0;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ST_OWN: begin
                hold_nxt = hold_inc;
                // Timeout fires on the edge where the count reaches MAX_HOLD,
                // so a contended owner keeps the pads exactly MAX_HOLD cycles.
                timeout  = (MAX_HOLD != 0) && (hold_inc == HMAX) && (|others);
                if (!req_ext[cand] || timeout) begin
                    // A voluntary drop wins over a simultaneous timeout.
                    preempt_nxt = req_ext[cand];
                    grant_nxt   = '0;
                    ptr_nxt     = ptr_after;
                    hold_nxt    = '0;
                    if (|others) begin
                        cand_nxt  = pick_rel;
                        tcnt_nxt  = '0;
                        state_nxt = ST_TURN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Arbiter state register; reset lands in IDLE with the pointer at 0.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cand    <= '0;
            tcnt    <= '0;
            hold    <= '0;
            grant   <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cand    <= cand_nxt;
            tcnt    <= tcnt_nxt;
            hold    <= hold_nxt;
            grant   <= grant_nxt;
            preempt <= preempt_nxt;
        end
    end

    // Pad drivers follow the owner's slice one cycle behind; any cycle
    // without an owner (including reset) tri-states every pad at once.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            io_out <= '0;
            io_oeb <= OEB_IN;
        end else if (state_nxt == ST_OWN) begin
            io_out <= od_arr[cand_nxt];
            io_oeb <= oe_arr[cand_nxt];
        end else begin
            io_out <= '0;
            io_oeb <= OEB_IN;
        end
    end

    io_in_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (io_in),
        .q   (in_sync)
    );

endmodule
